// File: rtl/sseg_mux_driver.sv
// Time-multiplexed common-anode 7-seg driver: per-frame input snapshot, PWM dim, blink, anode guard band.
// Outputs registered one cycle after internal scan state; free-running, no backpressure.
module sseg_mux_driver #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 16,
  parameter int DIM_BITS    = 4,
  parameter int BLINK_BITS  = 25
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   hex_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic [DIM_BITS-1:0]   brightness,
  output logic [DIGITS-1:0]     AN,
  output logic [6:0]            SSEG,
  output logic                  DP,
  output logic                  frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = $clog2(DIGITS);
  localparam logic [PW-1:0] PRE_MAX   = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD_END = PW'(GUARD);
  localparam logic [SW-1:0] SLOT_MAX  = SW'(DIGITS - 1);

  logic [PW-1:0]             prescaler_q, prescaler_d;
  logic [SW-1:0]             slot_q, slot_d;
  logic [DIM_BITS-1:0]       pwm_cnt_q;
  logic [BLINK_BITS-1:0]     blink_cnt_q;

  logic [DIGITS-1:0][3:0]    shadow_hex_q;
  logic [DIGITS-1:0]         shadow_dp_q;
  logic [DIGITS-1:0]         shadow_en_q;
  logic [DIGITS-1:0]         shadow_blink_q;
  logic [DIM_BITS-1:0]       shadow_bri_q;

  logic [DIGITS-1:0]         an_d;
  logic [6:0]                sseg_d;
  logic                      dp_d;

  logic slot_tick, snap, pwm_on, blink_phase, visible;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign slot_tick   = (prescaler_q == PRE_MAX);
  // Snapshot coincides with the slot wrap, so digit 0 always starts on fresh data.
  assign snap        = slot_tick && (slot_q == SLOT_MAX);
  assign prescaler_d = slot_tick ? '0 : prescaler_q + 1'b1;
  assign slot_d      = !slot_tick ? slot_q : ((slot_q == SLOT_MAX) ? '0 : slot_q + 1'b1);

  assign pwm_on      = (pwm_cnt_q <= shadow_bri_q);
  assign blink_phase = blink_cnt_q[BLINK_BITS-1];
  assign visible     = (prescaler_q >= GUARD_END) && shadow_en_q[slot_q] && pwm_on
                       && !(blink_phase && shadow_blink_q[slot_q]);

  always_comb begin
    an_d   = '1;
    sseg_d = 7'h7F;
    dp_d   = 1'b1;
    if (visible) begin
      an_d[slot_q] = 1'b0;
      sseg_d       = decode(shadow_hex_q[slot_q]);
      dp_d         = ~shadow_dp_q[slot_q];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler_q    <= '0;
      slot_q         <= '0;
      pwm_cnt_q      <= '0;
      blink_cnt_q    <= '0;
      shadow_hex_q   <= '0;
      shadow_dp_q    <= '0;
      shadow_en_q    <= '0;
      shadow_blink_q <= '0;
      shadow_bri_q   <= '0;
      AN             <= '1;
      SSEG           <= 7'h7F;
      DP             <= 1'b1;
      frame_tick     <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      slot_q      <= slot_d;
      pwm_cnt_q   <= pwm_cnt_q + 1'b1;
      blink_cnt_q <= blink_cnt_q + 1'b1;
      if (snap) begin
        shadow_hex_q   <= hex_in;
        shadow_dp_q    <= dp_in;
        shadow_en_q    <= digit_en;
        shadow_blink_q <= blink_mask;
        shadow_bri_q   <= brightness;
      end
      frame_tick <= snap;
      AN         <= an_d;
      SSEG       <= sseg_d;
      DP         <= dp_d;
    end
  end

endmodule

// File: doc/sseg_mux_driver.md
Name: sseg_mux_driver

Overview:
- Parametrised, time-multiplexed driver for a common-anode seven-segment bank of DIGITS digits (active-low anodes, segments and DP).
- Takes a packed hex word plus per-digit DP, enable and blink masks.
- Latches all inputs once per scan frame so the display never tears.
- Adds PWM brightness, blink, and an anode guard band that suppresses ghosting.
- Sits between application logic (UART/Morse decoders, counters) and the board's AN/SSEG/DP pins.

Parameters:
- DIGITS, 8: number of digits scanned (any value >= 2, not required to be a power of two).
- REFRESH_DIV, 50000: clk cycles per digit slot; must be > GUARD+1.
- GUARD, 16: cycles at the start of each slot with all anodes off.
- DIM_BITS, 4: brightness resolution in bits.
- BLINK_BITS, 25: width of the free-running blink counter; its MSB is the blink phase.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- hex_in  in  4*DIGITS  digit i value in hex_in[4i+3:4i]
- dp_in  in  DIGITS  1 = decimal point lit for digit i
- digit_en  in  DIGITS  1 = digit i may display; 0 = forced blank
- blink_mask  in  DIGITS  1 = digit i blanks during blink phase
- brightness  in  DIM_BITS  0 = dimmest (1/2^DIM_BITS duty), all-ones = full on
- AN  out  DIGITS  active-low anodes; at most one bit low at any time
- SSEG  out  7  active-low segments, SSEG[6:0] = g,f,e,d,c,b,a
- DP  out  1  active-low decimal point
- frame_tick  out  1  one-cycle pulse when a new frame snapshot is taken

Behaviour:
- Reset (async, reset_n=0):
  - prescaler=0, slot=0, pwm_cnt=0, blink_cnt=0.
  - All shadow registers = 0.
  - AN = all ones, SSEG = 7'h7F, DP = 1, frame_tick = 0.
  - Because shadow digit_en resets to 0, the display is blank until the first snapshot.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - slot_tick is asserted when prescaler == REFRESH_DIV-1.
- Slot counter:
  - Increments on slot_tick.
  - Wraps from DIGITS-1 to 0; it never visits values >= DIGITS.
- Snapshot:
  - On a slot_tick where slot == DIGITS-1, shadow registers <= hex_in, dp_in, digit_en, blink_mask, brightness.
  - frame_tick is registered high for exactly the following cycle.
  - Inputs are ignored at all other times, so mid-frame input changes never appear within the current frame.
- pwm_cnt (DIM_BITS wide) increments every clk and wraps naturally; pwm_on = (pwm_cnt <= shadow brightness).
- blink_cnt (BLINK_BITS wide) increments every clk and wraps; blink_phase = blink_cnt MSB.
- visible = (prescaler >= GUARD) & shadow_en[slot] & pwm_on & ~(blink_phase & shadow_blink[slot]).
- Output registers, one cycle of latency from the internal state:
  - AN[slot] = ~visible; all other AN bits = 1.
  - SSEG = visible ? decode(shadow_hex[slot]) : 7'h7F.
  - DP = visible ? ~shadow_dp[slot] : 1.
- Decode (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Segment, DP and AN changes occur only inside the guard window or while the digit is not visible, so no glitch is driven onto a lit digit.
- Simultaneous events: a snapshot and a slot wrap happen on the same edge; the digit 0 shown immediately after uses the new snapshot.
- Reset mid-frame: all outputs go to their blank values asynchronously, and scanning restarts at slot 0 after release.

Test Plan:
Bench parameters for all scenarios: DIGITS=4, REFRESH_DIV=8, GUARD=2, DIM_BITS=2, BLINK_BITS=6.
1. Reset release with hex_in=16'h3210, digit_en=4'hF, brightness=3 -> blank for the first 32 cycles. frame_tick pulses at cycle 32. Then AN cycles 1110,1101,1011,0111 per 8-cycle slot; each is low for 6 of 8 cycles. SSEG shows 1000000, 1111001, 0100100, 0110000 on the respective digits.
2. Change hex_in to 16'hFEDC mid-frame (slot 1) -> the remainder of the frame still shows 0..3. The next frame shows C, d, E, F (1000110, 0100001, 0000110, 0001110). frame_tick pulses once per 32 cycles.
3. brightness=0 -> the anode is low only when pwm_cnt==0, i.e. 1 cycle in 4 after the guard. brightness=1 -> 2 of 4 cycles low.
4. blink_mask=4'b0010, digit_en=4'hF -> digit 1 is dark whenever blink_cnt[5]=1 (alternating 32-cycle halves). Digits 0, 2 and 3 are unaffected.
5. digit_en=4'b0101, dp_in=4'b0100 -> AN bits 1 and 3 never go low. DP goes low only while AN[2] is low.
6. Assert reset_n=0 mid-slot 2 -> same cycle: AN=1111, SSEG=7'h7F, DP=1. After release, scanning restarts at slot 0 and the display stays blank until the next frame_tick.
